// File: rtl/swarm_runtime_config.sv
// Host-programmable configuration bank: a shared shadow bank is copied into the
// active bank of each selected tile once that tile has been quiesced.
//
// state   | meaning
// IDLE    | register writes accepted; a COMMIT write starts a commit
// DRAIN   | quiesce_req = mask, waiting for all masked acks or the drain timeout
// APPLY   | one cycle; masked active banks load the shadow bank at the edge
// RELEASE | quiesce_req dropped, waiting for masked acks to clear
module swarm_runtime_config #(
  parameter int N_TILES    = 1,
  parameter int N_CFG      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int VERSION    = 10,
  parameter logic [N_CFG*DATA_WIDTH-1:0] CFG_INIT = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 reg_wvalid,
  output logic                                 reg_wready,
  input  logic [ADDR_WIDTH-1:0]                reg_waddr,
  input  logic [DATA_WIDTH-1:0]                reg_wdata,
  input  logic                                 reg_arvalid,
  output logic                                 reg_arready,
  input  logic [ADDR_WIDTH-1:0]                reg_araddr,
  output logic                                 reg_rvalid,
  input  logic                                 reg_rready,
  output logic [DATA_WIDTH-1:0]                reg_rdata,
  output logic [N_TILES-1:0]                   quiesce_req,
  input  logic [N_TILES-1:0]                   quiesce_ack,
  output logic [N_TILES*N_CFG*DATA_WIDTH-1:0]  cfg_active,
  output logic [N_TILES-1:0]                   cfg_update
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int CW = (N_CFG > 1) ? $clog2(N_CFG) : 1;
  localparam int BW = N_CFG * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    APPLY   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [N_TILES-1:0]      mask_q;
  logic [31:0]             drain_cnt_q, drain_cnt_inc, timeout_ext;
  logic [DATA_WIDTH-1:0]   timeout_q;
  logic                    timeout_err_q;
  logic [BW-1:0]           shadow_q;
  logic [N_TILES*BW-1:0]   active_q;
  logic [N_TILES-1:0]      update_q;
  logic [IW-1:0]           widx, ridx;
  logic [CW-1:0]           wsel, rsel;
  logic                    wr_en, rd_en, wr_cfg, rd_cfg;
  logic                    acks_all, acks_none, timed_out;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign widx   = reg_waddr[ADDR_WIDTH-1:2];
  assign ridx   = reg_araddr[ADDR_WIDTH-1:2];
  assign wsel   = CW'(widx - IW'(4));
  assign rsel   = CW'(ridx - IW'(4));
  assign wr_cfg = (widx >= IW'(4)) && (widx < IW'(4 + N_CFG));
  assign rd_cfg = (ridx >= IW'(4)) && (ridx < IW'(4 + N_CFG));

  assign reg_wready  = (state_q == IDLE);
  assign reg_arready = !reg_rvalid || reg_rready;
  assign wr_en       = reg_wvalid && reg_wready;
  assign rd_en       = reg_arvalid && reg_arready;

  assign acks_all      = (quiesce_ack & mask_q) == mask_q;
  assign acks_none     = (quiesce_ack & mask_q) == '0;
  assign drain_cnt_inc = (&drain_cnt_q) ? drain_cnt_q : drain_cnt_q + 32'd1;
  assign timeout_ext   = 32'(timeout_q);
  assign timed_out     = (timeout_ext != 32'd0) && (drain_cnt_inc >= timeout_ext);

  assign cfg_active = active_q;
  assign cfg_update = update_q;

  always_comb begin
    state_d     = state_q;
    quiesce_req = '0;
    case (state_q)
      IDLE: begin
        if (wr_en && widx == IW'(2)) state_d = DRAIN;
      end
      DRAIN: begin
        quiesce_req = mask_q;
        if (acks_all)       state_d = APPLY;
        else if (timed_out) state_d = RELEASE;
      end
      APPLY: begin
        quiesce_req = mask_q;
        state_d     = RELEASE;
      end
      RELEASE: begin
        if (acks_none) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    if (ridx == IW'(0)) begin
      rd_word = DATA_WIDTH'(VERSION);
    end else if (ridx == IW'(1)) begin
      rd_word[0]   = (state_q != IDLE);
      rd_word[1]   = timeout_err_q;
      rd_word[3:2] = state_q;
    end else if (ridx == IW'(3)) begin
      rd_word = timeout_q;
    end else if (rd_cfg) begin
      rd_word = shadow_q[rsel*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q        <= '0;
      drain_cnt_q   <= '0;
      timeout_q     <= '0;
      timeout_err_q <= 1'b0;
      shadow_q      <= CFG_INIT;
      active_q      <= {N_TILES{CFG_INIT}};
      update_q      <= '0;
      reg_rvalid    <= 1'b0;
      reg_rdata     <= '0;
    end else begin
      update_q <= '0;
      // wr_en is only possible in IDLE, so the shadow bank is frozen during a commit
      if (wr_en) begin
        if (widx == IW'(2)) begin
          mask_q        <= reg_wdata[N_TILES-1:0];
          timeout_err_q <= 1'b0;
          drain_cnt_q   <= '0;
        end else if (widx == IW'(3)) begin
          timeout_q <= reg_wdata;
        end else if (wr_cfg) begin
          shadow_q[wsel*DATA_WIDTH +: DATA_WIDTH] <= reg_wdata;
        end
      end
      if (state_q == DRAIN && !acks_all) begin
        drain_cnt_q <= drain_cnt_inc;
        if (timed_out) timeout_err_q <= 1'b1;
      end
      if (state_q == APPLY) begin
        for (int t = 0; t < N_TILES; t++) begin
          if (mask_q[t]) begin
            active_q[t*BW +: BW] <= shadow_q;
            update_q[t]          <= 1'b1;
          end
        end
      end
      if (rd_en) begin
        reg_rvalid <= 1'b1;
        reg_rdata  <= rd_word;
      end else if (reg_rready) begin
        reg_rvalid <= 1'b0;
      end
    end
  end

endmodule
